// File: rtl/cmd_out_arbiter_if.sv
// Stream bundle for cmd_out_arbiter: the per-accelerator finish-notification inputs
// and the merged, TID-tagged command-out stream.
interface cmd_out_arbiter_if #(
    parameter int MAX_ACCS = 16,
    parameter int ACC_BITS = $clog2(MAX_ACCS)
);
    logic [64*MAX_ACCS-1:0] accStream_TDATA;
    logic [MAX_ACCS-1:0]    accStream_TVALID;
    logic [MAX_ACCS-1:0]    accStream_TLAST;
    logic [MAX_ACCS-1:0]    accStream_TREADY;

    logic [63:0]            outStream_TDATA;
    logic                   outStream_TVALID;
    logic                   outStream_TLAST;
    logic [ACC_BITS-1:0]    outStream_TID;
    logic                   outStream_TREADY;

    // The arbiter consumes the accelerator streams and drives the merged stream.
    modport master (
        input  accStream_TDATA,
        input  accStream_TVALID,
        input  accStream_TLAST,
        output accStream_TREADY,
        output outStream_TDATA,
        output outStream_TVALID,
        output outStream_TLAST,
        output outStream_TID,
        input  outStream_TREADY
    );

    modport slave (
        output accStream_TDATA,
        output accStream_TVALID,
        output accStream_TLAST,
        input  accStream_TREADY,
        input  outStream_TDATA,
        input  outStream_TVALID,
        input  outStream_TLAST,
        input  outStream_TID,
        output outStream_TREADY
    );
endinterface

// File: rtl/cmd_out_arbiter.sv
// Packet-level round-robin merge of accelerator finish notifications into one
// TID-tagged stream; a granted source keeps the output until its TLAST beat is taken.
module cmd_out_arbiter #(
    parameter  int MAX_ACCS = 16,
    localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
    input  logic              clk,
    input  logic              rst,
    cmd_out_arbiter_if.master bus,
    output logic [31:0]       pkt_count
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state;
    state_t              state_next;
    logic [ACC_BITS-1:0] sel;
    logic [ACC_BITS-1:0] last_grant;
    logic [ACC_BITS-1:0] winner;
    logic                hit;
    logic                slot_free;
    logic                accept;
    logic [MAX_ACCS-1:0] acc_ready;
    logic [63:0]         acc_data;
    logic [63:0]         out_data;
    logic                out_valid;
    logic                out_last;
    logic [ACC_BITS-1:0] out_tid;
    logic [31:0]         pkt_cnt;

    // Rotating index that wraps at MAX_ACCS, so unused encodings are never produced.
    function automatic logic [ACC_BITS-1:0] wrap_idx(input logic [ACC_BITS-1:0] base, input int k);
        return ACC_BITS'((int'(base) + k) % MAX_ACCS);
    endfunction

    assign slot_free = !out_valid || bus.outStream_TREADY;
    assign acc_data  = bus.accStream_TDATA[int'(sel)*64 +: 64];

    always_comb begin
        hit    = 1'b0;
        winner = '0;
        for (int k = 1; k <= MAX_ACCS; k++) begin
            if (!hit && bus.accStream_TVALID[wrap_idx(last_grant, k)]) begin
                hit    = 1'b1;
                winner = wrap_idx(last_grant, k);
            end
        end
    end

    // Ready only ever depends on state, sel and the output slot, never on any TVALID.
    always_comb begin
        state_next = state;
        acc_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) state_next = LOCK;
            end
            LOCK: begin
                acc_ready[sel] = slot_free;
                accept         = bus.accStream_TVALID[sel] && slot_free;
                if (accept && bus.accStream_TLAST[sel]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= '0;
            last_grant <= ACC_BITS'(MAX_ACCS - 1);
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_tid    <= '0;
            pkt_cnt    <= '0;
        end else begin
            if (state == IDLE && hit) sel <= winner;
            if (accept) begin
                out_data  <= acc_data;
                out_last  <= bus.accStream_TLAST[sel];
                out_tid   <= sel;
                out_valid <= 1'b1;
                if (bus.accStream_TLAST[sel]) begin
                    last_grant <= sel;
                    pkt_cnt    <= pkt_cnt + 32'd1;
                end
            end else if (bus.outStream_TREADY) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.accStream_TREADY = acc_ready;
    assign bus.outStream_TDATA  = out_data;
    assign bus.outStream_TVALID = out_valid;
    assign bus.outStream_TLAST  = out_last;
    assign bus.outStream_TID    = out_tid;
    assign pkt_count            = pkt_cnt;
endmodule

// File: tb/tb_cmd_out_arbiter.sv
// Randomized bench for cmd_out_arbiter: packet-level round-robin reference model feeds
// an expected-beat queue that a separate monitor drains against the merged output.
module tb_cmd_out_arbiter;
    localparam int NACC = 6;
    localparam int NB   = $clog2(NACC);

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0]   data;
        logic          last;
        logic [NB-1:0] tid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_count;

    always #5 clk = ~clk;

    cmd_out_arbiter_if #(.MAX_ACCS(NACC)) bus ();

    cmd_out_arbiter #(.MAX_ACCS(NACC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .pkt_count (pkt_count)
    );

    beat_t           src_q [NACC][$];
    exp_t            exp_q [$];
    int              got_order [$];
    int              want_order [$];
    int              checks = 0;
    int              failures = 0;
    int              valid_pct = 100;
    int              ready_mode = 0;
    int              cyc = 0;
    int              taken [NACC];
    logic [NACC-1:0] gate = '1;

    bit          m_locked;
    int          m_sel;
    int          m_last_grant;
    bit          m_slot;
    logic [31:0] m_count;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked     = 1'b0;
        m_sel        = 0;
        m_last_grant = NACC - 1;
        m_slot       = 1'b0;
        m_count      = '0;
        exp_q.delete();
    endtask

    task automatic push_beat(input int a, input logic [63:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[a].push_back(b);
    endtask

    task automatic push_packet(input int a, input int len);
        for (int i = 0; i < len; i++)
            push_beat(a, {$urandom, $urandom}, (i == len - 1));
    endtask

    // One clock of stimulus; the reference model predicts ready, slot and count for this cycle.
    task automatic applyStimulus();
        logic [NACC-1:0] v;
        logic [NACC-1:0] rdy;
        logic [NACC-1:0] exp_rdy;
        bit              out_rdy;
        bit              slot_free;
        bit              accepted;
        bit              found;
        exp_t            e;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_rdy = ($urandom_range(0, 99) < 70);
        endcase
        bus.outStream_TREADY = out_rdy;
        for (int a = 0; a < NACC; a++) begin
            v[a] = gate[a] && (src_q[a].size() > 0) && ($urandom_range(0, 99) < valid_pct);
            bus.accStream_TDATA[a*64 +: 64] = (src_q[a].size() > 0) ? src_q[a][0].data : 64'h0;
            bus.accStream_TLAST[a]          = (src_q[a].size() > 0) ? src_q[a][0].last : 1'b0;
        end
        bus.accStream_TVALID = v;
        #1;
        rdy       = bus.accStream_TREADY;
        slot_free = !m_slot || out_rdy;
        exp_rdy   = '0;
        if (m_locked && slot_free) exp_rdy[m_sel] = 1'b1;
        check("acc_tready", 64'(rdy), 64'(exp_rdy));
        check("out_tvalid", 64'(bus.outStream_TVALID), 64'(m_slot));
        check("pkt_count", 64'(pkt_count), 64'(m_count));
        accepted = m_locked && v[m_sel] && slot_free;
        if (!m_locked) begin
            found = 1'b0;
            for (int k = 1; k <= NACC; k++) begin
                if (!found && v[(m_last_grant + k) % NACC]) begin
                    found    = 1'b1;
                    m_locked = 1'b1;
                    m_sel    = (m_last_grant + k) % NACC;
                end
            end
        end else if (accepted) begin
            e.data = src_q[m_sel][0].data;
            e.last = src_q[m_sel][0].last;
            e.tid  = NB'(m_sel);
            exp_q.push_back(e);
            if (e.last) begin
                m_locked     = 1'b0;
                m_last_grant = m_sel;
                m_count      = m_count + 32'd1;
            end
        end
        m_slot = accepted ? 1'b1 : (out_rdy ? 1'b0 : m_slot);
        for (int a = 0; a < NACC; a++) begin
            if (v[a] && rdy[a]) begin
                src_q[a].delete(0);
                taken[a]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL out_beat: got unexpected beat %0h tid %0d, expected none",
                     bus.outStream_TDATA, bus.outStream_TID);
            return;
        end
        e = exp_q.pop_front();
        check("out_tdata", bus.outStream_TDATA, e.data);
        check("out_tlast", 64'(bus.outStream_TLAST), 64'(e.last));
        check("out_tid", 64'(bus.outStream_TID), 64'(e.tid));
        if (bus.outStream_TLAST) got_order.push_back(int'(bus.outStream_TID));
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && bus.outStream_TVALID && bus.outStream_TREADY) checkOutput();
    end

    task automatic checkOrder(input string name);
        check({name, "_len"}, 64'(got_order.size()), 64'(want_order.size()));
        for (int i = 0; i < want_order.size(); i++)
            if (i < got_order.size()) check(name, 64'(got_order[i]), 64'(want_order[i]));
    endtask

    function automatic bit all_idle();
        for (int a = 0; a < NACC; a++)
            if (src_q[a].size() != 0) return 1'b0;
        return (exp_q.size() == 0) && !m_slot && !m_locked;
    endfunction

    task automatic drain();
        int n = 0;
        while (!all_idle() && n < 400) begin
            applyStimulus();
            n++;
        end
        check("drain_done", 64'(all_idle()), 64'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        bus.accStream_TVALID = '0;
        bus.accStream_TLAST  = '0;
        bus.accStream_TDATA  = '0;
        bus.outStream_TREADY = 1'b0;
        for (int a = 0; a < NACC; a++) begin
            src_q[a].delete();
            taken[a] = 0;
        end
        model_reset();
        got_order.delete();
        gate = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int stall;
        bus.accStream_TDATA  = '0;
        bus.accStream_TVALID = '0;
        bus.accStream_TLAST  = '0;
        bus.outStream_TREADY = 1'b0;
        model_reset();
        doReset();
        #1;
        check("rst_out_tvalid", 64'(bus.outStream_TVALID), 64'd0);
        check("rst_out_tdata", bus.outStream_TDATA, 64'd0);
        check("rst_out_tlast", 64'(bus.outStream_TLAST), 64'd0);
        check("rst_out_tid", 64'(bus.outStream_TID), 64'd0);
        check("rst_acc_tready", 64'(bus.accStream_TREADY), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);

        $display("[TB] single source");
        ready_mode = 0;
        valid_pct  = 100;
        push_beat(2, 64'hA, 1'b0);
        push_beat(2, 64'hB, 1'b0);
        push_beat(2, 64'hC, 1'b1);
        drain();
        check("single_pkt_count", 64'(pkt_count), 64'd1);
        want_order = '{2};
        checkOrder("single_order");

        $display("[TB] fairness from reset");
        doReset();
        for (int r = 0; r < 2; r++) begin
            push_packet(0, 3);
            push_packet(1, 3);
            push_packet(3, 3);
        end
        n = 0;
        while (pkt_count != 32'd6 && n < 100) begin
            applyStimulus();
            n++;
        end
        check("fair_cycles", 64'(n), 64'd24);
        drain();
        want_order = '{0, 1, 3, 0, 1, 3};
        checkOrder("fair_order");

        $display("[TB] backpressure");
        ready_mode = 1;
        push_packet(4, 5);
        drain();
        ready_mode = 0;

        $display("[TB] mid-packet stall");
        got_order.delete();
        taken[1] = 0;
        push_packet(1, 3);
        push_packet(4, 2);
        stall = 0;
        n = 0;
        while (!all_idle() && n < 80) begin
            applyStimulus();
            n++;
            if (taken[1] >= 1 && stall < 5) begin
                gate[1] = 1'b0;
                stall++;
            end else begin
                gate[1] = 1'b1;
            end
        end
        gate = '1;
        drain();
        want_order = '{1, 4};
        checkOrder("stall_order");

        $display("[TB] random traffic");
        for (int round = 0; round < 4; round++) begin
            ready_mode = 2;
            valid_pct  = $urandom_range(50, 100);
            for (int p = 0; p < 8; p++)
                push_packet($urandom_range(0, NACC - 1), $urandom_range(1, 4));
            repeat (40) applyStimulus();
            ready_mode = 0;
            valid_pct  = 100;
            drain();
        end

        $display("[TB] reset mid-packet");
        taken[5] = 0;
        push_packet(5, 4);
        n = 0;
        while (taken[5] < 2 && n < 20) begin
            applyStimulus();
            n++;
        end
        check("midrst_pre_tvalid", 64'(bus.outStream_TVALID), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 64'(bus.outStream_TVALID), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_tready", 64'(bus.accStream_TREADY), 64'd0);
        doReset();
        push_packet(0, 2);
        drain();
        want_order = '{0};
        checkOrder("midrst_order");

        $display("[TB] wrap of grant and packet counter");
        got_order.delete();
        push_packet(5, 1);
        drain();
        @(negedge clk);
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_cnt;
        m_count = 32'hFFFF_FFFF;
        push_packet(0, 1);
        drain();
        check("wrap_pkt_count", 64'(pkt_count), 64'd0);
        want_order = '{5, 0};
        checkOrder("wrap_order");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
